// File: rtl/reduction_offload_arbiter_pkg.sv
// Shared helpers for the reduction offload arbiter: index-width derivation
// and default parameter values used by the top and its tag FIFO.
package reduction_offload_arbiter_pkg;

  localparam int unsigned DefaultNumChannels    = 2;
  localparam int unsigned DefaultDataWidth      = 64;
  localparam int unsigned DefaultMaxOutstanding = 4;

  // Width of an index into n entries; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reduction_offload_arbiter_tagfifo.sv
// Tag FIFO recording which channel issued each in-flight backend request.
// Caller guarantees no push when full and no pop when empty.
module reduction_offload_arbiter_tagfifo
  import reduction_offload_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 1,
  parameter int unsigned Depth     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [DataWidth-1:0]         data_i,
  input  logic                         pop_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = wrap_inc(rd_ptr_q);
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/reduction_offload_arbiter.sv
// Round-robin sharing of one in-order reduction backend among several router
// offload ports; a tag FIFO steers each backend response to its issuing channel.
module reduction_offload_arbiter
  import reduction_offload_arbiter_pkg::*;
#(
  parameter int unsigned NumChannels    = DefaultNumChannels,
  parameter int unsigned DataWidth      = DefaultDataWidth,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter type         op_t           = logic [3:0]
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  op_t  [NumChannels-1:0]                ch_req_op_i,
  input  logic [NumChannels-1:0][DataWidth-1:0] ch_req_operand1_i,
  input  logic [NumChannels-1:0][DataWidth-1:0] ch_req_operand2_i,
  input  logic [NumChannels-1:0]                ch_req_valid_i,
  output logic [NumChannels-1:0]                ch_req_ready_o,
  output logic [DataWidth-1:0]                  ch_resp_result_o,
  output logic [NumChannels-1:0]                ch_resp_valid_o,
  input  logic [NumChannels-1:0]                ch_resp_ready_i,
  output op_t                                   be_req_op_o,
  output logic [DataWidth-1:0]                  be_req_operand1_o,
  output logic [DataWidth-1:0]                  be_req_operand2_o,
  output logic                                  be_req_valid_o,
  input  logic                                  be_req_ready_i,
  input  logic [DataWidth-1:0]                  be_resp_result_i,
  input  logic                                  be_resp_valid_i,
  output logic                                  be_resp_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  err_o
);

  localparam int unsigned IdxW = idx_width(NumChannels);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;
  logic [IdxW-1:0]      lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]      grant, cand;
  logic                 any_valid, can_issue, req_hs;
  logic [CntW-1:0]      occupancy;
  logic [IdxW-1:0]      tag_head;
  logic                 fifo_empty;
  logic                 resp_valid_q, resp_valid_d;
  logic [IdxW-1:0]      resp_ch_q, resp_ch_d;
  logic [DataWidth-1:0] resp_data_q, resp_data_d;
  logic                 resp_drain, be_resp_hs, tag_pop, orphan;
  logic                 err_q, err_d;

  // A stalled grant stays locked while its channel still requests; otherwise
  // the first valid channel at or after the priority pointer wins.
  always_comb begin
    grant     = rr_ptr_q;
    cand      = rr_ptr_q;
    any_valid = 1'b0;
    if (lock_q && ch_req_valid_i[lock_idx_q]) begin
      grant     = lock_idx_q;
      any_valid = 1'b1;
    end else begin
      for (int i = NumChannels - 1; i >= 0; i--) begin
        cand = IdxW'((int'(rr_ptr_q) + i) % NumChannels);
        if (ch_req_valid_i[cand]) begin
          grant     = cand;
          any_valid = 1'b1;
        end
      end
    end
  end

  assign can_issue      = !rst_i && any_valid && (occupancy < CntW'(MaxOutstanding));
  assign req_hs         = can_issue && be_req_ready_i;
  assign be_req_valid_o = can_issue;

  always_comb begin
    ch_req_ready_o    = '0;
    be_req_op_o       = '0;
    be_req_operand1_o = '0;
    be_req_operand2_o = '0;
    if (req_hs) ch_req_ready_o[grant] = 1'b1;
    if (can_issue) begin
      be_req_op_o       = ch_req_op_i[grant];
      be_req_operand1_o = ch_req_operand1_i[grant];
      be_req_operand2_o = ch_req_operand2_i[grant];
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (req_hs) begin
      rr_ptr_d = (grant == IdxW'(NumChannels - 1)) ? '0 : grant + 1'b1;
    end else if (can_issue) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
  end

  reduction_offload_arbiter_tagfifo #(
    .DataWidth(IdxW),
    .Depth    (MaxOutstanding)
  ) i_tagfifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (req_hs),
    .data_i (grant),
    .pop_i  (tag_pop),
    .data_o (tag_head),
    .count_o(occupancy),
    .empty_o(fifo_empty)
  );

  // Response register accepts a new result when empty or being drained.
  assign resp_drain      = resp_valid_q && ch_resp_ready_i[resp_ch_q];
  assign be_resp_ready_o = !rst_i && (!resp_valid_q || resp_drain);
  assign be_resp_hs      = be_resp_valid_i && be_resp_ready_o;
  assign tag_pop         = be_resp_hs && !fifo_empty;
  assign orphan          = be_resp_hs && fifo_empty;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_ch_d    = resp_ch_q;
    resp_data_d  = resp_data_q;
    err_d        = err_q || orphan;
    if (tag_pop) begin
      resp_valid_d = 1'b1;
      resp_ch_d    = tag_head;
      resp_data_d  = be_resp_result_i;
    end else if (resp_drain) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_ch_q    <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_ch_q    <= resp_ch_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    ch_resp_valid_o = '0;
    if (resp_valid_q) ch_resp_valid_o[resp_ch_q] = 1'b1;
  end

  assign ch_resp_result_o = resp_data_q;
  assign outstanding_o    = occupancy;
  assign err_o            = err_q;

endmodule
